// File: rtl/echo_unit_if.sv
// Sample-path and keypad handshake bundle for the echo stage.
// The master side drives samples and level pulses; the slave side is the echo stage.
interface echo_unit_if;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               echo_up;
    logic               echo_down;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic [1:0]         echo_level;
    logic               busy;

    modport master (
        output sample_in, sample_valid, echo_up, echo_down,
        input  sample_out, sample_out_valid, echo_level, busy
    );

    modport slave (
        input  sample_in, sample_valid, echo_up, echo_down,
        output sample_out, sample_out_valid, echo_level, busy
    );
endinterface

// File: rtl/echo_unit.sv
// Feedback echo: y = sat16(x + (d >>> s)), d = output from 2^ADDR_W samples ago.
// Four-state sample FSM around a single-port synchronous delay RAM.
module echo_unit #(
    parameter int ADDR_W = 12
) (
    input  logic       clk,
    input  logic       reset,
    echo_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, MIX, WRITE} state_e;

    state_e             state_q, state_d;
    logic signed [15:0] x_q, x_d;
    logic [1:0]         mix_lvl_q, mix_lvl_d;
    logic [1:0]         level_q, level_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic               primed_q, primed_d;
    logic signed [15:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               ram_re, ram_we;

    logic [15:0]        mem [0:(1<<ADDR_W)-1];
    logic signed [15:0] rd_q;

    logic signed [15:0] d, d_scaled, y_mix;
    logic [16:0]        sum;

    // Mix datapath: until the first pointer wrap the RAM holds garbage, so d is 0.
    always_comb begin
        d = primed_q ? rd_q : 16'sd0;
        case (mix_lvl_q)
            2'd1:    d_scaled = d >>> 3;
            2'd2:    d_scaled = d >>> 2;
            2'd3:    d_scaled = d >>> 1;
            default: d_scaled = 16'sd0;
        endcase
        sum = {x_q[15], x_q} + {d_scaled[15], d_scaled};
        if (sum[16] != sum[15]) y_mix = sum[16] ? 16'sh8000 : 16'sh7fff;
        else                    y_mix = sum[15:0];
    end

    always_comb begin
        level_d = level_q;
        if (bus.echo_up && !bus.echo_down && level_q != 2'd3)
            level_d = level_q + 2'd1;
        else if (bus.echo_down && !bus.echo_up && level_q != 2'd0)
            level_d = level_q - 2'd1;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        mix_lvl_d   = mix_lvl_q;
        wr_ptr_d    = wr_ptr_q;
        primed_d    = primed_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_valid) begin
                    x_d       = bus.sample_in;
                    mix_lvl_d = level_q;
                    ram_re    = 1'b1;
                    state_d   = READ;
                end
            end
            READ: state_d = MIX;
            MIX: begin
                out_d       = y_mix;
                out_valid_d = 1'b1;
                state_d     = WRITE;
            end
            WRITE: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (&wr_ptr_q) primed_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            mix_lvl_q   <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            primed_q    <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            mix_lvl_q   <= mix_lvl_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            primed_q    <= primed_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: the RAM and its read register are not reset; primed_q masks stale contents.
    always_ff @(posedge clk) begin
        if (ram_we) mem[wr_ptr_q] <= out_q;
        if (ram_re) rd_q <= mem[wr_ptr_q];
    end

    assign bus.sample_out       = out_q;
    assign bus.sample_out_valid = out_valid_q;
    assign bus.echo_level       = level_q;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: doc/echo_unit.md
# echo_unit

Feedback echo stage between the music player's sample output and the codec/waveform-display sample path. Each accepted 16-bit signed sample is mixed with an attenuated copy of the output produced exactly 2^ADDR_W samples earlier, read from an on-chip delay RAM. The echo strength is stepped by one-cycle keypad pulses (`echo_up` / `echo_down`). Level 0 is a transparent bypass.

## Interface
- `ADDR_W`, default 12: delay RAM address width.
  - Echo delay is 2^ADDR_W samples (4096, about 85 ms at 48 kHz).
  - Reduce in simulation.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `sample_in`  in  16  signed input sample; sampled only on `sample_valid`.
- `sample_valid`  in  1  one-cycle pulse marking a new input sample.
- `echo_up`  in  1  one-cycle pulse: increment echo level.
- `echo_down`  in  1  one-cycle pulse: decrement echo level.
- `sample_out`  out  16  signed mixed sample; held until the next output.
- `sample_out_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `echo_level`  out  2  current level, 0..3.
- `busy`  out  1  high while the FSM is not IDLE.

## Operation
- **Level register:**
  - `echo_up` alone increments, saturating at 3.
  - `echo_down` alone decrements, saturating at 0.
  - Both in the same cycle: no change.
  - A change takes effect on the next accepted sample; a sample already in flight finishes with its latched level.
- **Gain per level:**
  - 0 = bypass, output = x.
  - 1: d>>>3.
  - 2: d>>>2.
  - 3: d>>>1.
  - All shifts are arithmetic, truncating toward −∞.
- **Mix rule:**
  - y = sat16(x + (d >>> s)), computed in 17-bit signed arithmetic.
  - Saturate to 0x7FFF / 0x8000.
  - d = RAM word at `wr_ptr`, i.e. y from 2^ADDR_W accepted samples ago.
- **RAM:**
  - 2^ADDR_W × 16, single port, synchronous read (1-cycle latency), synchronous write.
  - Always stores y, including in bypass, so the echo is immediately coherent when the level is raised.
- **Priming:**
  - The `primed` flag clears on reset and sets when `wr_ptr` wraps from 2^ADDR_W−1 to 0.
  - While `primed`=0, d is forced to 0. RAM contents after power-up are never used.
- **FSM states:** IDLE, READ, MIX, WRITE.
  - IDLE: on `sample_valid`, latch x and level, present `wr_ptr` to RAM, go to READ. Otherwise stay.
  - READ: RAM data settles; go to MIX.
  - MIX: register y; go to WRITE.
  - WRITE: write y at `wr_ptr`; `wr_ptr`++ (mod 2^ADDR_W); drive `sample_out`=y and pulse `sample_out_valid`; return to IDLE.
- `sample_valid` arriving while not in IDLE is ignored. The sample is dropped and state is unaffected. At 48 kHz against 100 MHz this never occurs in the system.
- **Reset** (any time, including mid-sample):
  - FSM goes to IDLE; `wr_ptr`=0; `primed`=0.
  - Outputs: `sample_out`=0, `sample_out_valid`=0, `echo_level`=0, `busy`=0.
  - An in-flight sample is discarded, with no RAM write.

## Timing
- Cycle 0: `sample_valid` is high in IDLE.
- Cycle 1: READ.
- Cycle 2: MIX.
- Cycle 3: WRITE. `sample_out_valid` is high and `sample_out` is updated, both registered.
  - Latency is therefore exactly 3 cycles.
  - Minimum spacing between accepted samples is 4 cycles.
- `busy` is high in cycles 1–3.
- The level register updates in the cycle after the pulse.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:**
  - Hold `reset`=0: all outputs 0.
  - Release, then send x=0x1234 at level 0: `sample_out`=0x1234 and `sample_out_valid` 3 cycles later, `busy` high for cycles 1–3.
- **Level control:**
  - 5× `echo_up`: `echo_level` reaches 3 and holds.
  - `echo_up`+`echo_down` together: stays 3.
  - 4× `echo_down`: 0.
- **Echo:**
  - Set ADDR_W=3, level 3.
  - Send 0x4000 then 7 zeros: outputs 0x4000, 0×7.
  - Sample 8 (x=0): output 0x2000.
  - Sample 16: output 0x1000.
- **Unprimed and saturation:**
  - Before the first wrap, level 3, x=0x7000: output 0x7000 (d forced 0).
  - After the wrap, x=0x7000 with d=0x7000: 0x7000+0x3800 saturates to 0x7FFF.
  - Negative case: x=0x9000 with d=0x9000 gives 0x8000.
- **Busy drop:** send `sample_valid` at cycles 0 and 2: only one `sample_out_valid` (cycle 3), and `wr_ptr` advances by 1.
- **Reset mid-sample:** assert `reset` during MIX: no `sample_out_valid`, `wr_ptr`=0, and the next sample at level 3 before a wrap returns x unchanged.
